// File: rtl/snd_pkg.sv
// Shared sample/integrator types and the integrator clamp used by the audio PDM path.
package snd_pkg;
   localparam int PCM_W   = 16;
   localparam int INT_W   = 20;
   localparam int FS      = 2**15;
   localparam int INT_MAX = 2**(INT_W-1) - 1;

   typedef logic signed [PCM_W-1:0] pcm_t;
   typedef logic signed [INT_W-1:0] integ_t;
   // Two guard bits hold int + x - fb without wrapping before the clamp.
   typedef logic signed [INT_W+1:0] wide_t;

   function automatic integ_t sat_int(input wide_t v);
      if (v > wide_t'(INT_MAX))
         return integ_t'(INT_MAX);
      else if (v < -wide_t'(INT_MAX))
         return integ_t'(-INT_MAX);
      else
         return integ_t'(v);
   endfunction
endpackage

// File: rtl/sd2_mod.sv
// 2nd-order delta-sigma core, advances one step per ce; 1-cycle register latency, no backpressure.
module sd2_mod
   import snd_pkg::*;
(
   input  logic clk,
   input  logic async_nreset,
   input  logic ce,
   input  pcm_t x,
   output logic pdm_out,
   output logic clip
);
   integ_t int1;
   integ_t int2;
   integ_t int1_nx;
   integ_t int2_nx;
   wide_t  fb;
   wide_t  sum1;
   wide_t  sum2;
   logic   clamped;

   always_comb begin
      fb      = pdm_out ? wide_t'(FS) : -wide_t'(FS);
      sum1    = wide_t'(int1) + wide_t'(x) - fb;
      int1_nx = sat_int(sum1);
      // Second stage integrates the already-updated first stage.
      sum2    = wide_t'(int2) + wide_t'(int1_nx) - fb;
      int2_nx = sat_int(sum2);
      clamped = (wide_t'(int1_nx) != sum1) || (wide_t'(int2_nx) != sum2);
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         int1    <= '0;
         int2    <= '0;
         pdm_out <= 1'b0;
         clip    <= 1'b0;
      end else begin
         clip <= 1'b0;
         if (ce) begin
            int1    <= int1_nx;
            int2    <= int2_nx;
            pdm_out <= !int2_nx[INT_W-1];
            clip    <= clamped;
         end
      end
   end
endmodule

// File: rtl/audio_pdm.sv
// PCM capture, optional DC block (SND_DCBLOCK_EN), volume, divider and 2nd-order PDM to SND_OUT.
// pcm_valid -> scaled in 2 cycles (3 with DC block); no backpressure, samples are strobed in.
module audio_pdm
   import snd_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int DC_SHIFT = 10
) (
   input  logic             clk,
   input  logic             async_nreset,
   input  logic [PCM_W-1:0] pcm_in,
   input  logic             pcm_valid,
   input  logic [7:0]       volume,
   input  logic             mute,
   output logic             pdm_out,
   output logic             pdm_ce,
   output logic             clip
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   pcm_t               sample_q;
   pcm_t               gain_in;
   pcm_t               scaled;
   logic signed [23:0] product;
   logic [CNT_W-1:0]   cnt;
   logic               ce;

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset)
         sample_q <= '0;
      else if (pcm_valid)
         sample_q <= pcm_in;
   end

`ifdef SND_DCBLOCK_EN
   localparam int DC_W = PCM_W + DC_SHIFT;

   logic signed [DC_W-1:0] dc_acc;
   logic signed [DC_W:0]   dc_err;
   logic signed [PCM_W:0]  y_raw;
   pcm_t                   dc_int;
   pcm_t                   y_q;
   logic                   cap_q;

   always_comb begin
      dc_int = dc_acc[DC_W-1:DC_SHIFT];
      dc_err = (DC_W+1)'($signed({sample_q, {DC_SHIFT{1'b0}}})) - (DC_W+1)'(dc_acc);
      y_raw  = (PCM_W+1)'(sample_q) - (PCM_W+1)'(dc_int);
   end

   // cap_q marks the cycle sample_q holds a fresh sample, so the tracker steps once per sample.
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         dc_acc <= '0;
         y_q    <= '0;
         cap_q  <= 1'b0;
      end else begin
         cap_q <= pcm_valid;
         if (cap_q)
            dc_acc <= dc_acc + DC_W'(dc_err >>> DC_SHIFT);
         if (y_raw[PCM_W] != y_raw[PCM_W-1])
            y_q <= y_raw[PCM_W] ? {1'b1, {(PCM_W-1){1'b0}}} : {1'b0, {(PCM_W-1){1'b1}}};
         else
            y_q <= y_raw[PCM_W-1:0];
      end
   end

   assign gain_in = y_q;
`else
   assign gain_in = sample_q;
`endif

   assign product = 24'(gain_in) * 24'($signed({1'b0, volume}));

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset)
         scaled <= '0;
      else
         scaled <= mute ? '0 : pcm_t'(product >>> 8);
   end

   assign ce = (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         cnt    <= '0;
         pdm_ce <= 1'b0;
      end else begin
         cnt    <= ce ? '0 : cnt + CNT_W'(1);
         pdm_ce <= ce;
      end
   end

   sd2_mod u_mod (
      .clk          (clk),
      .async_nreset (async_nreset),
      .ce           (ce),
      .x            (scaled),
      .pdm_out      (pdm_out),
      .clip         (clip)
   );
endmodule

// File: tb/tb_audio_pdm.sv
// Scoreboarded bench for audio_pdm: reset, latency, gain and PDM ones-density per input level.
module tb_audio_pdm;
   import snd_pkg::*;

   localparam int N_WIN = 2048;
   localparam int TOL   = (N_WIN * 3) / 1000;
   localparam int DC_SH = 10;
`ifdef SND_DCBLOCK_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        async_nreset;
   logic [15:0] pcm_in;
   logic        pcm_valid;
   logic [7:0]  volume;
   logic        mute;
   logic        pdm_out, pdm_ce, clip;
   logic [15:0] pcm_in1;
   logic        pcm_valid1;
   logic        mute1;
   logic        pdm_out1, pdm_ce1, clip1;

   int n_chk  = 0;
   int n_pass = 0;
   int sq[$];
   int dq[$];
   int y_m    = 0;
   int dc_m   = 0;

   always #5 clk = ~clk;

   audio_pdm #(.CLK_DIV(4), .DC_SHIFT(DC_SH)) dut (
      .clk(clk), .async_nreset(async_nreset), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
      .volume(volume), .mute(mute), .pdm_out(pdm_out), .pdm_ce(pdm_ce), .clip(clip)
   );

   audio_pdm #(.CLK_DIV(1), .DC_SHIFT(DC_SH)) dut1 (
      .clk(clk), .async_nreset(async_nreset), .pcm_in(pcm_in1), .pcm_valid(pcm_valid1),
      .volume(volume), .mute(mute1), .pdm_out(pdm_out1), .pdm_ce(pdm_ce1), .clip(clip1)
   );

   task automatic check(input string tag, input int obs, input int exp, input int tol);
      n_chk++;
      if (obs - exp > tol || exp - obs > tol)
         $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      else
         n_pass++;
   endtask

   function automatic int gain(input int y, input int vol, input bit m);
      return m ? 0 : (y * vol) >>> 8;
   endfunction

   function automatic int exp_ones(input int x);
      return (N_WIN * (32768 + x) + 32768) / 65536;
   endfunction

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Steady gain input after a capture of s (DC tracker steps once per capture).
   task automatic capture_model(input int s);
`ifdef SND_DCBLOCK_EN
      dc_m = dc_m + (((s <<< DC_SH) - dc_m) >>> DC_SH);
      y_m  = sat16(s - (dc_m >>> DC_SH));
`else
      y_m  = s;
`endif
   endtask

   task automatic measure(input string tag, input bit chk_clip);
      int ones = 0;
      int got  = 0;
      int cl   = 0;
      repeat (64 * 4) @(posedge clk);
      for (int c = 0; c < N_WIN * 4 + 64 && got < N_WIN; c++) begin
         @(posedge clk); #1;
         if (pdm_ce) begin
            got++;
            ones += int'(pdm_out);
            cl   += int'(clip);
         end
      end
      check({tag, "_ce"}, got, N_WIN, 0);
      check({tag, "_dens"}, ones, dq.pop_front(), TOL);
      if (chk_clip)
         check({tag, "_clip"}, cl, 0, 0);
   endtask

   task automatic run_level(input string tag, input int s, input int vol, input bit m,
                            input bit chk_clip);
      int x;
      @(negedge clk);
      pcm_in    = s[15:0];
      pcm_valid = 1'b1;
      volume    = vol[7:0];
      mute      = m;
      capture_model(s);
      x = gain(y_m, vol, m);
      sq.push_back(x);
      dq.push_back(exp_ones(x));
      @(negedge clk);
      pcm_valid = 1'b0;
      repeat (LAT + 1) @(posedge clk);
      #1;
      check({tag, "_x"}, int'(dut.scaled), sq.pop_front(), 0);
      measure(tag, chk_clip);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int x;
      async_nreset = 1'b0;
      pcm_in = '0; pcm_valid = 1'b0; volume = 8'd255; mute = 1'b0;
      pcm_in1 = '0; pcm_valid1 = 1'b0; mute1 = 1'b0;

      // Reset held: activity on the inputs must not reach the outputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pcm_in = 16'h7FFF; pcm_valid = 1'b1;
         @(posedge clk); #1;
         check("rst_pdm_out", int'(pdm_out), 0, 0);
         check("rst_pdm_ce", int'(pdm_ce), 0, 0);
         check("rst_clip", int'(clip), 0, 0);
         check("rst_scaled", int'(dut.scaled), 0, 0);
         @(negedge clk);
         pcm_valid = 1'b0;
      end

      @(negedge clk);
      async_nreset = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!pdm_ce && n < 20);
      check("first_pdm_ce", n, 4, 0);
      check("ce_div1", int'(pdm_ce1), 1, 0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!pdm_ce && n < 20);
      check("pdm_ce_period", n, 4, 0);

      // CLK_DIV=1 instance: gain latency, previous value one cycle before.
      @(negedge clk);
      pcm_in1 = 16'h1234; pcm_valid1 = 1'b1; volume = 8'd255;
      sq.push_back(gain(32'sh1234, 255, 1'b0));
      @(negedge clk);
      pcm_valid1 = 1'b0;
      repeat (LAT - 2) @(posedge clk);
      #1;
      check("lat_early", int'(dut1.scaled), 0, 0);
      @(posedge clk); #1;
      check("lat_scaled", int'(dut1.scaled), sq.pop_front(), 0);

      run_level("full", 32767, 255, 1'b0, 1'b0);
      run_level("zero", 0, 255, 1'b0, 1'b1);
      run_level("neg", -16384, 128, 1'b0, 1'b1);
      run_level("mute", 16384, 255, 1'b1, 1'b1);

      @(negedge clk);
      mute = 1'b0;
      x = gain(y_m, 255, 1'b0);
      sq.push_back(x);
      dq.push_back(exp_ones(x));
      @(posedge clk); #1;
      check("unmute_x", int'(dut.scaled), sq.pop_front(), 0);
      measure("unmute", 1'b1);

`ifdef SND_DCBLOCK_EN
      // Constant input through the DC block settles to a 50% bitstream.
      @(negedge clk);
      pcm_in1 = 16'h4000; pcm_valid1 = 1'b1;
      dq.push_back(N_WIN / 2);
      repeat (16384) @(posedge clk);
      begin
         int ones = 0;
         for (int c = 0; c < N_WIN; c++) begin
            @(posedge clk); #1;
            ones += int'(pdm_out1);
         end
         check("dc_dens", ones, dq.pop_front(), N_WIN / 100);
      end
      @(negedge clk);
      pcm_valid1 = 1'b0;
`endif

      // Asynchronous reset mid-operation clears state without waiting for an edge.
      @(posedge clk); #2;
      async_nreset = 1'b0;
      #1;
      check("arst_scaled", int'(dut.scaled), 0, 0);
      check("arst_int1", int'(dut.u_mod.int1), 0, 0);
      check("arst_pdm_out", int'(pdm_out), 0, 0);
      check("arst_cnt", int'(dut.cnt), 0, 0);
      @(negedge clk);
      async_nreset = 1'b1;
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
